// File: rtl/hci_core_starve_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// hci_core_starve_arbiter_pkg
// Shared types and default channel widths for the starvation-aware HCI core
// arbiter and its winner-selection sub-module.
//   starve_arb_state_e : arbiter operating state (IDLE / NORMAL / STARVE)
//   HCI_DEFAULT_*      : default hci_core channel widths
//   idx_width()        : index width for N requesters (never below 1 bit)
// -----------------------------------------------------------------------------
package hci_core_starve_arbiter_pkg;

   localparam int unsigned HCI_DEFAULT_DW = 32;
   localparam int unsigned HCI_DEFAULT_AW = 32;
   localparam int unsigned HCI_DEFAULT_BW = 8;
   localparam int unsigned HCI_DEFAULT_WW = 32;
   localparam int unsigned HCI_DEFAULT_OW = 1;
   localparam int unsigned HCI_DEFAULT_UW = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      NORMAL = 2'd1,
      STARVE = 2'd2
   } starve_arb_state_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hci_starve_arb_sel.sv
// -----------------------------------------------------------------------------
// hci_starve_arb_sel
// Combinational winner picker. Starving requesters take absolute precedence
// (lowest index wins); otherwise the highest priority wins and ties are broken
// by the first requester at or after i_rr_ptr, wrapping around.
//   i_req    : request vector
//   i_prio   : packed per-requester priority (PW bits each, higher wins)
//   i_starve : per-requester starvation flags
//   i_rr_ptr : round-robin start index for tie-breaking
//   o_winner : selected index (0 when no request)
//   o_valid  : at least one request present
// -----------------------------------------------------------------------------
module hci_starve_arb_sel
   import hci_core_starve_arbiter_pkg::*;
#(
   parameter int unsigned NB_REQ = 4,
   parameter int unsigned PW     = 2,
   parameter int unsigned IW     = idx_width(NB_REQ)
) (
   input  logic [NB_REQ-1:0]    i_req,
   input  logic [NB_REQ*PW-1:0] i_prio,
   input  logic [NB_REQ-1:0]    i_starve,
   input  logic [IW-1:0]        i_rr_ptr,
   output logic [IW-1:0]        o_winner,
   output logic                 o_valid
);

   logic [PW-1:0] w_max;
   logic          w_found;
   int unsigned   w_best_dist;
   int unsigned   w_dist;

   always_comb begin
      w_max       = '0;
      w_found     = 1'b0;
      w_best_dist = NB_REQ;
      w_dist      = 0;
      o_winner    = '0;
      o_valid     = |i_req;

      for (int unsigned k = 0; k < NB_REQ; k++) begin
         if (i_req[k] && (i_prio[k*PW +: PW] > w_max)) begin
            w_max = i_prio[k*PW +: PW];
         end
      end

      if (|(i_req & i_starve)) begin
         for (int unsigned k = 0; k < NB_REQ; k++) begin
            if (!w_found && i_req[k] && i_starve[k]) begin
               o_winner = IW'(k);
               w_found  = 1'b1;
            end
         end
      end else begin
         // Cyclic distance from the round-robin pointer; the smallest distance
         // among max-priority requesters wins the tie.
         for (int unsigned k = 0; k < NB_REQ; k++) begin
            w_dist = (k >= 32'(i_rr_ptr)) ? (k - 32'(i_rr_ptr))
                                          : (k + NB_REQ - 32'(i_rr_ptr));
            if (i_req[k] && (i_prio[k*PW +: PW] == w_max) && (w_dist < w_best_dist)) begin
               w_best_dist = w_dist;
               o_winner    = IW'(k);
            end
         end
      end
   end

endmodule

// File: rtl/hci_core_starve_arbiter.sv
// -----------------------------------------------------------------------------
// hci_core_starve_arbiter
// Arbitrates NB_REQ HCI core requesters onto one shared channel using static
// priority, round-robin tie-breaking and per-requester stall counters that
// force service once a requester has waited max_stall_i cycles. One-cycle
// read responses are routed back to the requester granted in the previous
// cycle.
//   clk_i, rst_i, clear_i : clock, async active-high reset, sync clear
//   in_*                  : requester-side channel fields (packed per port)
//   in_r_data/opc/user_o  : response payload, shared by all requesters
//   out_*                 : shared master channel fields
//   prio_i                : packed per-requester priority
//   max_stall_i           : starvation threshold (0 disables forcing)
//   starve_o              : per-requester starvation flags
// -----------------------------------------------------------------------------
module hci_core_starve_arbiter
   import hci_core_starve_arbiter_pkg::*;
#(
   parameter int unsigned NB_REQ = 4,
   parameter int unsigned PW     = 2,
   parameter int unsigned SW     = 4,
   parameter int unsigned DW     = HCI_DEFAULT_DW,
   parameter int unsigned AW     = HCI_DEFAULT_AW,
   parameter int unsigned BW     = HCI_DEFAULT_BW,
   parameter int unsigned WW     = HCI_DEFAULT_WW,
   parameter int unsigned OW     = HCI_DEFAULT_OW,
   parameter int unsigned UW     = HCI_DEFAULT_UW,
   localparam int unsigned BEW     = DW/BW,
   localparam int unsigned BOW_RAW = (DW/WW) * $clog2(WW/BW),
   localparam int unsigned BOW     = (BOW_RAW > 0) ? BOW_RAW : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   // requester side
   input  logic [NB_REQ-1:0]     in_req_i,
   output logic [NB_REQ-1:0]     in_gnt_o,
   input  logic [NB_REQ*AW-1:0]  in_add_i,
   input  logic [NB_REQ-1:0]     in_wen_i,
   input  logic [NB_REQ*DW-1:0]  in_data_i,
   input  logic [NB_REQ*BEW-1:0] in_be_i,
   input  logic [NB_REQ*BOW-1:0] in_boffs_i,
   input  logic [NB_REQ*UW-1:0]  in_user_i,
   input  logic [NB_REQ-1:0]     in_lrdy_i,
   output logic [NB_REQ-1:0]     in_r_valid_o,
   output logic [DW-1:0]         in_r_data_o,
   output logic [OW-1:0]         in_r_opc_o,
   output logic [UW-1:0]         in_r_user_o,
   // shared master side
   output logic                  out_req_o,
   input  logic                  out_gnt_i,
   output logic [AW-1:0]         out_add_o,
   output logic                  out_wen_o,
   output logic [DW-1:0]         out_data_o,
   output logic [BEW-1:0]        out_be_o,
   output logic [BOW-1:0]        out_boffs_o,
   output logic [UW-1:0]         out_user_o,
   output logic                  out_lrdy_o,
   input  logic                  out_r_valid_i,
   input  logic [DW-1:0]         out_r_data_i,
   input  logic [OW-1:0]         out_r_opc_i,
   input  logic [UW-1:0]         out_r_user_i,
   // control / status
   input  logic [NB_REQ*PW-1:0]  prio_i,
   input  logic [SW-1:0]         max_stall_i,
   output logic [NB_REQ-1:0]     starve_o
);

   localparam int unsigned IW = idx_width(NB_REQ);

   starve_arb_state_e r_state, w_state_d;

   logic [IW-1:0]     r_rr_ptr, w_rr_d;
   logic [IW-1:0]     r_winner_q;
   logic              r_valid_q;
   logic [SW-1:0]     r_cnt   [NB_REQ];
   logic [SW-1:0]     w_cnt_d [NB_REQ];

   logic [IW-1:0]     w_winner;
   logic              w_win_valid;
   logic              w_hs;
   logic [NB_REQ-1:0] w_starve;
   logic [NB_REQ-1:0] w_starve_d;
   logic [NB_REQ-1:0] w_sel_oh;

   hci_starve_arb_sel #(
      .NB_REQ (NB_REQ),
      .PW     (PW),
      .IW     (IW)
   ) i_sel (
      .i_req    (in_req_i),
      .i_prio   (prio_i),
      .i_starve (w_starve),
      .i_rr_ptr (r_rr_ptr),
      .o_winner (w_winner),
      .o_valid  (w_win_valid)
   );

   // Threshold compare is combinational so a new max_stall_i acts immediately.
   always_comb begin
      w_starve = '0;
      for (int unsigned k = 0; k < NB_REQ; k++) begin
         w_starve[k] = (max_stall_i != '0) && (r_cnt[k] >= max_stall_i);
      end
   end
   assign starve_o = w_starve;

   assign out_req_o = |in_req_i;
   assign w_hs      = out_req_o & out_gnt_i & w_win_valid;

   always_comb begin
      w_sel_oh = '0;
      for (int unsigned k = 0; k < NB_REQ; k++) begin
         w_sel_oh[k] = w_win_valid && (w_winner == IW'(k));
      end
   end

   assign in_gnt_o = w_sel_oh & {NB_REQ{out_gnt_i}};

   // Forward payload mux
   always_comb begin
      out_add_o   = '0;
      out_wen_o   = 1'b0;
      out_data_o  = '0;
      out_be_o    = '0;
      out_boffs_o = '0;
      out_user_o  = '0;
      out_lrdy_o  = 1'b0;
      for (int unsigned k = 0; k < NB_REQ; k++) begin
         if (w_sel_oh[k]) begin
            out_add_o   = in_add_i[k*AW +: AW];
            out_wen_o   = in_wen_i[k];
            out_data_o  = in_data_i[k*DW +: DW];
            out_be_o    = in_be_i[k*BEW +: BEW];
            out_boffs_o = in_boffs_i[k*BOW +: BOW];
            out_user_o  = in_user_i[k*UW +: UW];
            out_lrdy_o  = in_lrdy_i[k];
         end
      end
   end

   // Response routing
   always_comb begin
      in_r_valid_o = '0;
      for (int unsigned k = 0; k < NB_REQ; k++) begin
         in_r_valid_o[k] = out_r_valid_i & r_valid_q & (r_winner_q == IW'(k));
      end
   end
   assign in_r_data_o = out_r_data_i;
   assign in_r_opc_o  = out_r_opc_i;
   assign in_r_user_o = out_r_user_i;

   // Stall counters: cleared when idle or granted, otherwise saturating count.
   always_comb begin
      w_starve_d = '0;
      for (int unsigned k = 0; k < NB_REQ; k++) begin
         if (!in_req_i[k] || (w_hs && w_sel_oh[k])) begin
            w_cnt_d[k] = '0;
         end else if (r_cnt[k] != '1) begin
            w_cnt_d[k] = r_cnt[k] + 1'b1;
         end else begin
            w_cnt_d[k] = r_cnt[k];
         end
         w_starve_d[k] = in_req_i[k] && (max_stall_i != '0) && (w_cnt_d[k] >= max_stall_i);
      end
   end

   assign w_rr_d = (w_winner == IW'(NB_REQ-1)) ? '0 : (w_winner + 1'b1);

   // Next state uses next-cycle counters; requests are assumed held (a
   // requester keeps req until granted), so current req stands in for next.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         IDLE: begin
            if (|in_req_i) w_state_d = (|w_starve_d) ? STARVE : NORMAL;
         end
         NORMAL, STARVE: begin
            if (!(|in_req_i))      w_state_d = IDLE;
            else if (|w_starve_d)  w_state_d = STARVE;
            else                   w_state_d = NORMAL;
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_rr_ptr   <= '0;
         r_winner_q <= '0;
         r_valid_q  <= 1'b0;
         for (int unsigned k = 0; k < NB_REQ; k++) r_cnt[k] <= '0;
      end else if (clear_i) begin
         r_state    <= IDLE;
         r_rr_ptr   <= '0;
         r_winner_q <= '0;
         r_valid_q  <= 1'b0;
         for (int unsigned k = 0; k < NB_REQ; k++) r_cnt[k] <= '0;
      end else begin
         r_state   <= w_state_d;
         r_valid_q <= w_hs;
         if (w_hs) begin
            r_rr_ptr   <= w_rr_d;
            r_winner_q <= w_winner;
         end
         for (int unsigned k = 0; k < NB_REQ; k++) r_cnt[k] <= w_cnt_d[k];
      end
   end

endmodule

// File: tb/tb_hci_core_starve_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hci_core_starve_arbiter
// Directed bench for hci_core_starve_arbiter (NB_REQ=4, PW=2, SW=4, default
// channel widths). Inputs change just after the falling edge; outputs are
// sampled 1 time unit later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_hci_core_starve_arbiter;
   import hci_core_starve_arbiter_pkg::*;

   localparam int unsigned NB_REQ = 4;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         clear_i;
   logic [3:0]   in_req_i;
   logic [3:0]   in_gnt_o;
   logic [127:0] in_add_i;
   logic [3:0]   in_wen_i;
   logic [127:0] in_data_i;
   logic [15:0]  in_be_i;
   logic [7:0]   in_boffs_i;
   logic [3:0]   in_user_i;
   logic [3:0]   in_lrdy_i;
   logic [3:0]   in_r_valid_o;
   logic [31:0]  in_r_data_o;
   logic [0:0]   in_r_opc_o;
   logic [0:0]   in_r_user_o;
   logic         out_req_o;
   logic         out_gnt_i;
   logic [31:0]  out_add_o;
   logic         out_wen_o;
   logic [31:0]  out_data_o;
   logic [3:0]   out_be_o;
   logic [1:0]   out_boffs_o;
   logic [0:0]   out_user_o;
   logic         out_lrdy_o;
   logic         out_r_valid_i;
   logic [31:0]  out_r_data_i;
   logic [0:0]   out_r_opc_i;
   logic [0:0]   out_r_user_i;
   logic [7:0]   prio_i;
   logic [3:0]   max_stall_i;
   logic [3:0]   starve_o;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk_i = ~clk_i;

   hci_core_starve_arbiter #(
      .NB_REQ (4),
      .PW     (2),
      .SW     (4)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clear_i       (clear_i),
      .in_req_i      (in_req_i),
      .in_gnt_o      (in_gnt_o),
      .in_add_i      (in_add_i),
      .in_wen_i      (in_wen_i),
      .in_data_i     (in_data_i),
      .in_be_i       (in_be_i),
      .in_boffs_i    (in_boffs_i),
      .in_user_i     (in_user_i),
      .in_lrdy_i     (in_lrdy_i),
      .in_r_valid_o  (in_r_valid_o),
      .in_r_data_o   (in_r_data_o),
      .in_r_opc_o    (in_r_opc_o),
      .in_r_user_o   (in_r_user_o),
      .out_req_o     (out_req_o),
      .out_gnt_i     (out_gnt_i),
      .out_add_o     (out_add_o),
      .out_wen_o     (out_wen_o),
      .out_data_o    (out_data_o),
      .out_be_o      (out_be_o),
      .out_boffs_o   (out_boffs_o),
      .out_user_o    (out_user_o),
      .out_lrdy_o    (out_lrdy_o),
      .out_r_valid_i (out_r_valid_i),
      .out_r_data_i  (out_r_data_i),
      .out_r_opc_i   (out_r_opc_i),
      .out_r_user_i  (out_r_user_i),
      .prio_i        (prio_i),
      .max_stall_i   (max_stall_i),
      .starve_o      (starve_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance to the next falling edge (passes one rising edge).
   task automatic next_cycle();
      @(negedge clk_i);
   endtask

   logic [3:0] exp_oh [5];
   logic [3:0] saw_gnt;

   initial begin
      rst_i         = 1'b1;
      clear_i       = 1'b0;
      in_req_i      = 4'b0101;
      in_add_i      = {32'hA003, 32'hA002, 32'hA001, 32'hA000};
      in_wen_i      = 4'b0101;
      in_data_i     = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
      in_be_i       = {4'h8, 4'h4, 4'h2, 4'h1};
      in_boffs_i    = {2'd3, 2'd2, 2'd1, 2'd0};
      in_user_i     = 4'b1000;
      in_lrdy_i     = 4'b1111;
      out_gnt_i     = 1'b0;
      out_r_valid_i = 1'b1;
      out_r_data_i  = 32'h0;
      out_r_opc_i   = 1'b0;
      out_r_user_i  = 1'b0;
      prio_i        = '0;
      max_stall_i   = 4'd0;

      // ---------------- reset ----------------
      next_cycle();
      next_cycle();
      #1;
      check("rst_out_req",  32'(out_req_o), 32'd1);
      check("rst_in_gnt",   32'(in_gnt_o), 32'd0);
      check("rst_r_valid",  32'(in_r_valid_o), 32'd0);
      check("rst_starve",   32'(starve_o), 32'd0);
      check("rst_rr_ptr",   32'(dut.r_rr_ptr), 32'd0);
      check("rst_state",    32'(dut.r_state), 32'(IDLE));
      check("rst_cnt0",     32'(dut.r_cnt[0]), 32'd0);

      // --------------- priority ---------------
      next_cycle();
      rst_i         = 1'b0;
      out_r_valid_i = 1'b0;
      in_req_i      = 4'b1111;
      prio_i        = {2'd3, 2'd1, 2'd2, 2'd0};
      out_gnt_i     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("prio_gnt", 32'(in_gnt_o), 32'b1000);
         next_cycle();
      end
      #1;
      check("prio_add",   out_add_o, 32'hA003);
      check("prio_data",  out_data_o, 32'hD3);
      check("prio_be",    32'(out_be_o), 32'h8);
      check("prio_wen",   32'(out_wen_o), 32'd0);
      check("prio_boffs", 32'(out_boffs_o), 32'd3);
      check("prio_user",  32'(out_user_o), 32'd1);
      check("prio_nostarve", 32'(starve_o), 32'd0);
      check("prio_cnt0_counts", 32'(dut.r_cnt[0]), 32'd4);
      check("prio_rr_wrap", 32'(dut.r_rr_ptr), 32'd0);
      check("prio_state", 32'(dut.r_state), 32'(NORMAL));

      // drop all requests for one cycle: counters clear, FSM idles
      in_req_i = 4'b0000;
      #1;
      check("idle_out_req", 32'(out_req_o), 32'd0);
      check("idle_gnt",     32'(in_gnt_o), 32'd0);
      next_cycle();
      #1;
      check("idle_state", 32'(dut.r_state), 32'(IDLE));
      check("idle_cnt0",  32'(dut.r_cnt[0]), 32'd0);

      // -------------- round-robin --------------
      in_req_i  = 4'b1111;
      prio_i    = '0;
      exp_oh[0] = 4'b0001;
      exp_oh[1] = 4'b0010;
      exp_oh[2] = 4'b0100;
      exp_oh[3] = 4'b1000;
      exp_oh[4] = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("rr_gnt", 32'(in_gnt_o), 32'(exp_oh[i]));
         if (i == 4) check("rr_ptr_wrapped", 32'(dut.r_rr_ptr), 32'd0);
         next_cycle();
      end
      #1;
      check("rr_ptr_after", 32'(dut.r_rr_ptr), 32'd1);
      in_req_i = 4'b0000;
      next_cycle();

      // --------------- starvation ---------------
      in_req_i    = 4'b1001;
      prio_i      = {2'd3, 2'd0, 2'd0, 2'd0};
      max_stall_i = 4'd3;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stv_wait_gnt",    32'(in_gnt_o), 32'b1000);
         check("stv_wait_starve", 32'(starve_o), 32'd0);
         next_cycle();
      end
      #1;
      check("stv_cnt0",   32'(dut.r_cnt[0]), 32'd3);
      check("stv_starve", 32'(starve_o), 32'b0001);
      check("stv_state",  32'(dut.r_state), 32'(STARVE));
      check("stv_gnt",    32'(in_gnt_o), 32'b0001);
      check("stv_add",    out_add_o, 32'hA000);
      next_cycle();
      #1;
      check("stv_cnt0_clr", 32'(dut.r_cnt[0]), 32'd0);
      check("stv_cnt3",     32'(dut.r_cnt[3]), 32'd1);
      check("stv_after_gnt", 32'(in_gnt_o), 32'b1000);
      check("stv_after_state", 32'(dut.r_state), 32'(NORMAL));
      in_req_i    = 4'b0000;
      max_stall_i = 4'd0;
      next_cycle();

      // ------------- response routing -------------
      in_req_i = 4'b0100;
      prio_i   = '0;
      #1;
      check("rsp_gnt", 32'(in_gnt_o), 32'b0100);
      check("rsp_wen", 32'(out_wen_o), 32'd1);
      next_cycle();
      in_req_i      = 4'b0000;
      out_r_valid_i = 1'b1;
      out_r_data_i  = 32'hCAFE;
      out_r_opc_i   = 1'b1;
      #1;
      check("rsp_route", 32'(in_r_valid_o), 32'b0100);
      check("rsp_data",  in_r_data_o, 32'hCAFE);
      check("rsp_opc",   32'(in_r_opc_o), 32'd1);
      next_cycle();
      #1;
      check("rsp_spurious", 32'(in_r_valid_o), 32'd0);
      out_r_valid_i = 1'b0;
      next_cycle();

      // --------------- backpressure ---------------
      in_req_i    = 4'b1111;
      out_gnt_i   = 1'b0;
      max_stall_i = 4'd15;
      saw_gnt     = '0;
      for (int i = 0; i < 20; i++) begin
         #1;
         saw_gnt = saw_gnt | in_gnt_o;
         if (i == 14) check("bp_starve_below", 32'(starve_o), 32'd0);
         if (i == 15) check("bp_starve_at",    32'(starve_o), 32'b1111);
         next_cycle();
      end
      #1;
      check("bp_no_gnt",   32'(saw_gnt | in_gnt_o), 32'd0);
      check("bp_out_req",  32'(out_req_o), 32'd1);
      check("bp_sat0",     32'(dut.r_cnt[0]), 32'd15);
      check("bp_sat3",     32'(dut.r_cnt[3]), 32'd15);
      check("bp_state",    32'(dut.r_state), 32'(STARVE));
      max_stall_i = 4'd0;
      #1;
      check("bp_disable_now", 32'(starve_o), 32'd0);
      in_req_i = 4'b0000;
      next_cycle();

      // ------------- clear mid-flight -------------
      // rr_ptr is 3 here; build up counters first.
      in_req_i  = 4'b1111;
      prio_i    = {2'd0, 2'd0, 2'd1, 2'd0};
      out_gnt_i = 1'b0;
      next_cycle();
      #1;
      check("clr_pre_cnt0", 32'(dut.r_cnt[0]), 32'd1);
      out_gnt_i = 1'b1;
      clear_i   = 1'b1;
      #1;
      check("clr_gnt", 32'(in_gnt_o), 32'b0010);
      next_cycle();
      clear_i       = 1'b0;
      in_req_i      = 4'b0000;
      out_r_valid_i = 1'b1;
      #1;
      check("clr_r_valid_drop", 32'(in_r_valid_o), 32'd0);
      check("clr_rr_ptr",       32'(dut.r_rr_ptr), 32'd0);
      check("clr_cnt0",         32'(dut.r_cnt[0]), 32'd0);
      check("clr_cnt2",         32'(dut.r_cnt[2]), 32'd0);
      check("clr_state",        32'(dut.r_state), 32'(IDLE));
      out_r_valid_i = 1'b0;
      next_cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Absolute guard against a stalled run.
   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
